// File: rtl/tx_polyphase_filter_pkg.sv
// tx_polyphase_filter_pkg: shared TX shaping constants, S(8,7) limits and default RRC taps
package tx_polyphase_filter_pkg;
  localparam int DEF_OS = 4;
  localparam int DEF_NUM_SYM = 6;
  localparam logic signed [7:0] SAT_MAX = 8'sh7F;
  localparam logic signed [7:0] SAT_MIN = 8'sh80;
  // RRC roll-off 0.5, 4 samples/symbol, 6-symbol span, peak 0.875; tap 23 in the MSBs
  localparam logic [DEF_OS*DEF_NUM_SYM*8-1:0] RRC_COEFS =
    192'hFEFF020402F9F1F60F316070_60310FF6F1F9020402FFFE00;
  typedef struct packed {
    logic valid;
    logic sign;
  } sym_t;
endpackage

// File: rtl/tx_polyphase_filter_sat_trunc.sv
// sat_trunc: drops fractional LSBs, then clamps to the narrower signed output width
module sat_trunc #(
  parameter int NBT_IN = 11,
  parameter int NBF_IN = 7,
  parameter int NBT_OUT = 8,
  parameter int NBF_OUT = 7
) (
  input  logic signed [NBT_IN-1:0]  value,
  output logic signed [NBT_OUT-1:0] result
);
  localparam int SH = NBF_IN - NBF_OUT;
  localparam int W = NBT_IN - SH;
  logic [W-1:0] t;
  logic fits;
  assign t = value[NBT_IN-1:SH];
  assign fits = (&t[W-1:NBT_OUT-1]) | ~(|t[W-1:NBT_OUT-1]);
  assign result = fits ? t[NBT_OUT-1:0] : {t[W-1], {(NBT_OUT-1){~t[W-1]}}};
endmodule

// File: rtl/tx_polyphase_filter.sv
// tx_polyphase_filter: QPSK polyphase pulse shaper, one output sample per i_en strobe
module tx_polyphase_filter
  import tx_polyphase_filter_pkg::*;
#(
  parameter int OS = DEF_OS,
  parameter int NUM_SYM = DEF_NUM_SYM,
  parameter int NBT_COEF = 8,
  parameter int NBF_COEF = 7,
  parameter int NBT_OUT = 8,
  parameter int NBF_OUT = 7
) (
  input  logic                             clk,
  input  logic                             i_reset,
  input  logic                             i_en,
  input  logic                             i_bit_I,
  input  logic                             i_bit_Q,
  input  logic                             i_sym_valid,
  input  logic [OS*NUM_SYM*NBT_COEF-1:0]   i_coefs,
  output logic                             o_bit_rd,
  output logic signed [NBT_OUT-1:0]        o_data_I,
  output logic signed [NBT_OUT-1:0]        o_data_Q,
  output logic                             o_valid
);
  localparam int PW = (OS > 1) ? $clog2(OS) : 1;
  localparam int AW = NBT_COEF + $clog2(NUM_SYM);
  logic [PW-1:0] phase;
  sym_t sym_i [NUM_SYM];
  sym_t sym_q [NUM_SYM];
  logic signed [AW-1:0] tap [NUM_SYM];
  logic signed [AW-1:0] acc_i, acc_q;
  logic signed [NBT_OUT-1:0] sat_i, sat_q;
  assign o_bit_rd = i_en && !i_reset && phase == PW'(OS - 1);
  // one tap per symbol slot for the current phase, shared by both branches
  always_comb begin
    acc_i = '0;
    acc_q = '0;
    for (int k = 0; k < NUM_SYM; k++) begin
      tap[k] = AW'($signed(i_coefs[(k*OS + int'(phase))*NBT_COEF +: NBT_COEF]));
      acc_i = acc_i + (!sym_i[k].valid ? AW'(0) : sym_i[k].sign ? -tap[k] : tap[k]);
      acc_q = acc_q + (!sym_q[k].valid ? AW'(0) : sym_q[k].sign ? -tap[k] : tap[k]);
    end
  end
  sat_trunc #(.NBT_IN(AW), .NBF_IN(NBF_COEF), .NBT_OUT(NBT_OUT), .NBF_OUT(NBF_OUT))
    u_sat_i (.value(acc_i), .result(sat_i));
  sat_trunc #(.NBT_IN(AW), .NBF_IN(NBF_COEF), .NBT_OUT(NBT_OUT), .NBF_OUT(NBF_OUT))
    u_sat_q (.value(acc_q), .result(sat_q));
  always_ff @(posedge clk) begin
    if (i_reset) begin
      phase <= '0;
      for (int k = 0; k < NUM_SYM; k++) begin
        sym_i[k] <= '0;
        sym_q[k] <= '0;
      end
      o_data_I <= '0;
      o_data_Q <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= i_en;
      if (i_en) begin
        phase <= phase == PW'(OS - 1) ? '0 : phase + 1'b1;
        o_data_I <= sat_i;
        o_data_Q <= sat_q;
      end
      if (o_bit_rd) begin
        for (int k = NUM_SYM - 1; k > 0; k--) begin
          sym_i[k] <= sym_i[k-1];
          sym_q[k] <= sym_q[k-1];
        end
        sym_i[0] <= {i_sym_valid, i_bit_I};
        sym_q[0] <= {i_sym_valid, i_bit_Q};
      end
    end
  end
endmodule

// File: tb/tb_tx_polyphase_filter.sv
// tb_tx_polyphase_filter: directed table and sequence checks of the TX polyphase shaper
module tb_tx_polyphase_filter;
  import tx_polyphase_filter_pkg::*;
  logic clk = 1'b0;
  logic i_reset, i_en, i_bit_I, i_bit_Q, i_sym_valid;
  logic [191:0] i_coefs;
  logic o_bit_rd, o_valid;
  logic signed [7:0] o_data_I, o_data_Q;
  logic rd_s;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic e, r, s, bi, bq, rd, v;
    int di, dq;
  } vec_t;
  vec_t tbl [18];

  tx_polyphase_filter dut (
    .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_bit_I(i_bit_I), .i_bit_Q(i_bit_Q),
    .i_sym_valid(i_sym_valid), .i_coefs(i_coefs), .o_bit_rd(o_bit_rd),
    .o_data_I(o_data_I), .o_data_Q(o_data_Q), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic step(input logic e, r, s, b_i, b_q);
    i_en = e;
    i_reset = r;
    i_sym_valid = s;
    i_bit_I = b_i;
    i_bit_Q = b_q;
    #1 rd_s = o_bit_rd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic rd, v, input int di, dq);
    chk({tag, " rd"}, 32'(rd_s), 32'(rd));
    chk({tag, " valid"}, 32'(o_valid), 32'(v));
    chk({tag, " I"}, 32'(o_data_I), di);
    chk({tag, " Q"}, 32'(o_data_Q), dq);
  endtask

  // one symbol enters on strobe 4; the ramp taps make sample n after entry equal n LSB
  task automatic impulse(input logic b_i, b_q, input bit gap);
    int ex, hi, hq;
    for (int t = 0; t < 24; t++) i_coefs[t*8 +: 8] = 8'(t + 1);
    step(0, 1, 0, 0, 0);
    for (int s = 1; s <= 30; s++) begin
      step(1, 0, s == 4, b_i, b_q);
      ex = (s >= 5 && s <= 28) ? s - 4 : 0;
      hi = b_i ? -ex : ex;
      hq = b_q ? -ex : ex;
      chk_out($sformatf("imp%0d%0d%0d s%0d", b_i, b_q, gap, s), s % 4 == 0, 1'b1, hi, hq);
      if (gap && s % 2 == 0) begin
        step(0, 0, 0, 0, 0);
        chk_out($sformatf("gap s%0d", s), 1'b0, 1'b0, hi, hq);
      end
    end
  endtask

  initial begin
    i_en = 0; i_reset = 1; i_sym_valid = 0; i_bit_I = 0; i_bit_Q = 0;
    i_coefs = RRC_COEFS;
    @(posedge clk);
    #1;
    step(1, 1, 0, 0, 0);
    chk_out("reset", 1'b0, 1'b0, 0, 0);

    // invalid symbols only: silent output, consume on every 4th strobe
    for (int n = 1; n <= 24; n++) begin
      step(1, 0, 0, n[0], n[1]);
      chk_out($sformatf("zero n%0d", n), n % 4 == 0, 1'b1, 0, 0);
    end

    impulse(0, 0, 0);
    impulse(1, 0, 0);
    impulse(0, 1, 1);

    // saturation ramp-up, held gap and mid-stream reset at phase 2
    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[3]  = '{1, 0, 1, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 1, 0, 1, 1, 1, 0, 0};
    tbl[5]  = '{1, 0, 1, 0, 1, 0, 1, 127, -127};
    tbl[6]  = '{1, 0, 1, 0, 1, 0, 1, 127, -127};
    tbl[7]  = '{1, 0, 1, 0, 1, 0, 1, 127, -127};
    tbl[8]  = '{1, 0, 1, 0, 1, 1, 1, 127, -127};
    tbl[9]  = '{1, 0, 1, 0, 1, 0, 1, 127, -128};
    tbl[10] = '{0, 0, 1, 0, 1, 0, 0, 127, -128};
    tbl[11] = '{1, 0, 1, 0, 1, 0, 1, 127, -128};
    tbl[12] = '{1, 1, 1, 0, 1, 0, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[14] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[15] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
    i_coefs = {24{8'h7F}};
    for (int i = 0; i < 18; i++) begin
      step(tbl[i].e, tbl[i].r, tbl[i].s, tbl[i].bi, tbl[i].bq);
      chk_out($sformatf("tbl%0d", i), tbl[i].rd, tbl[i].v, tbl[i].di, tbl[i].dq);
    end

    // full shifter of +1 on I and -1 on Q
    step(0, 1, 0, 0, 0);
    for (int s = 1; s <= 28; s++) begin
      step(1, 0, 1, 0, 1);
      if (s >= 25) chk_out($sformatf("full s%0d", s), s % 4 == 0, 1'b1, 127, -128);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tx_polyphase_filter.md
TX_POLYPHASE_FILTER -- requirements
Module: tx_polyphase_filter

Interface
REQ-001 SHALL have parameter OS, default 4; oversampling factor, i.e. output samples per symbol.
REQ-002 SHALL have parameter NUM_SYM, default 6; filter span in symbols, so NUM_TAPS = OS*NUM_SYM = 24.
REQ-003 SHALL have parameters NBT_COEF=8 and NBF_COEF=7; coefficient format S(8,7).
REQ-004 SHALL have parameters NBT_OUT=8 and NBF_OUT=7; output format S(8,7), matching the receiver equalizer input.
REQ-005 SHALL have port clk, input, 1 bit; single clock, all logic on rising edge.
REQ-006 SHALL have port i_reset, input, 1 bit; synchronous, active-high reset.
REQ-007 SHALL have port i_en, input, 1 bit; output-rate strobe, one output sample per asserted cycle.
REQ-008 SHALL have port i_bit_I, input, 1 bit; QPSK in-phase bit, 0 maps to +1 and 1 maps to -1.
REQ-009 SHALL have port i_bit_Q, input, 1 bit; QPSK quadrature bit, same mapping as i_bit_I.
REQ-010 SHALL have port i_sym_valid, input, 1 bit; when low, the consumed symbol is a zero symbol.
REQ-011 SHALL have port i_coefs, input, NUM_TAPS*NBT_COEF bits; packed taps, tap t at bits [(t+1)*NBT_COEF-1 : t*NBT_COEF], shared by I and Q.
REQ-012 SHALL have port o_bit_rd, output, 1 bit; symbol-consume pulse.
REQ-013 SHALL have ports o_data_I and o_data_Q, output, NBT_OUT bits each, signed; shaped samples.
REQ-014 SHALL have port o_valid, output, 1 bit; the output registers were updated in the previous cycle.

Function
REQ-015 SHALL keep a phase counter of width clog2(OS) that increments on i_en and wraps from OS-1 to 0.
REQ-016 SHALL keep NUM_SYM-deep symbol shifters of {valid, sign} per branch, where index 0 is the newest symbol.
REQ-017 SHALL assert o_bit_rd combinationally as i_en AND (phase == OS-1).
REQ-018 SHALL, on a cycle with o_bit_rd high, shift {i_sym_valid, i_bit_I} and {i_sym_valid, i_bit_Q} into index 0 of the shifters; shifters SHALL hold otherwise.
REQ-019 SHALL compute, combinationally for phase p, sum over k=0..NUM_SYM-1 of s[k]*h[k*OS+p], where s is +1, -1, or 0 when the entry is invalid.
REQ-020 SHALL implement each term by coefficient negation or selection, with no multipliers.
REQ-021 SHALL size the accumulator at NBT_COEF+clog2(NUM_SYM) bits (11 bits), with NBF_COEF fractional bits.
REQ-022 SHALL saturate the accumulator to S(8,7) by discarding integer MSBs: if the discarded bits plus the output sign bit are all equal, pass the value through; otherwise clamp to 0x7F when positive or 0x80 when negative.
REQ-023 SHALL register o_data_I, o_data_Q and o_valid on i_en, using the current phase and shifter contents; the output therefore lags the strobe by 1 cycle.
REQ-024 SHALL drive o_valid as a 1-cycle pulse following each i_en, and SHALL hold o_data when i_en is low.
REQ-025 SHALL, at phase 0 following a consume, include the newly shifted symbol in the sum.
REQ-026 SHALL change i_coefs only with i_en low; a change with i_en high has undefined output for that sample only.

Reset
REQ-027 SHALL, with i_reset high, clear phase to 0, clear all shifter valid and sign bits, set o_data_I=o_data_Q=0 and o_valid=0, and force o_bit_rd=0.
REQ-028 SHALL give reset priority over i_en, including when asserted mid-symbol; the next symbol is then consumed on the 4th i_en after reset release.
REQ-029 SHALL produce exactly 0 for all outputs after reset until the first valid symbol enters.

Structure
REQ-030 SHALL place OS, NUM_SYM, the S(8,7) saturation limits and the default RRC coefficient vector (roll-off 0.5) in a shared tx package.
REQ-031 SHALL use one sub-module, sat_trunc, for parameterised saturation and truncation, reusable by the receive path.
REQ-032 SHALL have the I and Q branches share the phase counter and tap selection logic.

Verification
REQ-033 SHALL cover: reset, then 24 continuous i_en with i_sym_valid=0 -> o_data=0 throughout, and o_bit_rd pulses on i_en numbers 4, 8, 12, ...
REQ-034 SHALL cover: single valid symbol (bit 0) then zeros, with coefficients h[t]=t+1 (LSB units) -> o_data_I sequence 1..24 LSB over the 24 samples after entry, then 0.
REQ-035 SHALL cover: bits I=1, Q=0 impulse -> o_data_I equals the negated o_data_Q sequence.
REQ-036 SHALL cover: all taps 0x7F and all symbols +1 -> o_data saturates at 0x7F; all symbols -1 -> 0x80.
REQ-037 SHALL cover: i_en gapped one cycle in three -> outputs identical to the continuous case, with o_valid only after strobes.
REQ-038 SHALL cover: i_reset asserted at phase 2 mid-stream -> outputs 0 the next cycle and phase restarts at 0.
